// File: rtl/trng_pkg.sv
// Shared constants and state encoding for the TRNG sample controller.
package trng_pkg;

  localparam int unsigned TRNG_SAMPLE_DIV   = 560;
  localparam int unsigned TRNG_ENTROPY_BITS = 2;
  localparam int unsigned TRNG_STUCK_LIMIT  = 16;
  localparam int unsigned TRNG_TEMP_W       = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } trng_state_e;

endpackage

// File: rtl/vn_debias.sv
// Von Neumann debiaser: pairs raw bits, emits the first bit of each unequal pair.
module vn_debias (
  input  logic clk_200KHz,
  input  logic rst_n,
  input  logic clr,
  input  logic in_vld,
  input  logic in_bit,
  output logic out_vld,
  output logic out_bit
);

  logic pending_q, pending_d;
  logic first_q, first_d;

  // Emit on the second bit of a pair when it differs from the stored first bit
  assign out_vld = in_vld & pending_q & (first_q ^ in_bit);
  assign out_bit = first_q;

  // Pairing state update
  always_comb begin
    pending_d = pending_q;
    first_d   = first_q;
    if (clr) begin
      pending_d = 1'b0;
      first_d   = 1'b0;
    end else if (in_vld) begin
      if (pending_q) begin
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
        first_d   = in_bit;
      end
    end
  end

  // Pairing state register
  always_ff @(posedge clk_200KHz or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      first_q   <= first_d;
    end
  end

endmodule

// File: rtl/trng_sample_ctrl.sv
// Samples the temperature word once per I2C read loop, debiases and packs bytes.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = TRNG_SAMPLE_DIV,
  parameter int unsigned ENTROPY_BITS = TRNG_ENTROPY_BITS,
  parameter int unsigned STUCK_LIMIT  = TRNG_STUCK_LIMIT
) (
  input  logic                   clk_200KHz,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [TRNG_TEMP_W-1:0] temp_data,
  output logic [7:0]             rnd_data,
  output logic                   rnd_valid,
  input  logic                   rnd_ready,
  output logic                   overrun,
  output logic                   health_fail
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned REP_W = $clog2(STUCK_LIMIT);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(STUCK_LIMIT - 1);
  localparam logic [REP_W-1:0] REP_TRIP = REP_W'(STUCK_LIMIT - 2);

  trng_state_e            state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [TRNG_TEMP_W-1:0] prev_q, prev_d;
  logic                   prev_vld_q, prev_vld_d;
  logic [REP_W-1:0]       rep_q, rep_d;
  logic [6:0]             shift_q, shift_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             rnd_data_q, rnd_data_d;
  logic                   rnd_valid_q, rnd_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   health_fail_q, health_fail_d;

  logic tick_c, same_c, stuck_c, raw_c, accept_c, byte_done_c;
  logic vn_in_vld_c, vn_clr_c, vn_out_vld, vn_out_bit;

  // Sample strobe and stuck-sensor detection; a stuck tick feeds nothing downstream
  assign tick_c      = (state_q == RUN) && en && (div_q == DIV_LAST);
  assign same_c      = prev_vld_q && (temp_data == prev_q);
  assign stuck_c     = tick_c && same_c && (rep_q == REP_TRIP);
  assign raw_c       = ^temp_data[ENTROPY_BITS-1:0];
  assign vn_in_vld_c = tick_c && !stuck_c;
  assign vn_clr_c    = (state_q != RUN) || !en || stuck_c;
  assign accept_c    = rnd_valid_q && rnd_ready;
  assign byte_done_c = vn_out_vld && (cnt_q == 3'd7);

  vn_debias u_vn_debias (
    .clk_200KHz (clk_200KHz),
    .rst_n      (rst_n),
    .clr        (vn_clr_c),
    .in_vld     (vn_in_vld_c),
    .in_bit     (raw_c),
    .out_vld    (vn_out_vld),
    .out_bit    (vn_out_bit)
  );

  // Next-state: FSM, divider, health counter, packer and output handshake
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    prev_d        = prev_q;
    prev_vld_d    = prev_vld_q;
    rep_d         = rep_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    rnd_data_d    = rnd_data_q;
    rnd_valid_d   = rnd_valid_q;
    overrun_d     = overrun_q;
    health_fail_d = health_fail_q;

    if (accept_c) rnd_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        div_d         = '0;
        prev_d        = '0;
        prev_vld_d    = 1'b0;
        rep_d         = '0;
        shift_d       = '0;
        cnt_d         = '0;
        overrun_d     = 1'b0;
        health_fail_d = 1'b0;
        if (en) state_d = RUN;
      end
      RUN: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (tick_c) begin
          prev_d     = temp_data;
          prev_vld_d = 1'b1;
          if (!same_c)               rep_d = '0;
          else if (rep_q != REP_MAX) rep_d = rep_q + REP_W'(1);
        end
        if (stuck_c) begin
          state_d       = FAIL;
          health_fail_d = 1'b1;
          shift_d       = '0;
          cnt_d         = '0;
        end else if (vn_out_vld) begin
          shift_d = {shift_q[5:0], vn_out_bit};
          cnt_d   = cnt_q + 3'd1;
          if (byte_done_c) begin
            shift_d = '0;
            if (!rnd_valid_q || rnd_ready) begin
              rnd_data_d  = {shift_q, vn_out_bit};
              rnd_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      FAIL: begin
        health_fail_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Dropping en restarts everything except a byte already on the output
    if (!en) begin
      state_d       = IDLE;
      div_d         = '0;
      prev_d        = '0;
      prev_vld_d    = 1'b0;
      rep_d         = '0;
      shift_d       = '0;
      cnt_d         = '0;
      overrun_d     = 1'b0;
      health_fail_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_200KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_q         <= '0;
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
      rep_q         <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      rnd_data_q    <= '0;
      rnd_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      prev_q        <= prev_d;
      prev_vld_q    <= prev_vld_d;
      rep_q         <= rep_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      rnd_data_q    <= rnd_data_d;
      rnd_valid_q   <= rnd_valid_d;
      overrun_q     <= overrun_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign rnd_data    = rnd_data_q;
  assign rnd_valid   = rnd_valid_q;
  assign overrun     = overrun_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Bench for trng_sample_ctrl: directed vector table plus randomized model comparison.
module tb_trng_sample_ctrl;

  localparam int unsigned SDIV  = 4;
  localparam int unsigned EBITS = 1;
  localparam int unsigned SLIM  = 4;

  logic        clk_200KHz = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] temp_data;
  logic [7:0]  rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic        overrun;
  logic        health_fail;

  int checks   = 0;
  int failures = 0;

  trng_sample_ctrl #(
    .SAMPLE_DIV   (SDIV),
    .ENTROPY_BITS (EBITS),
    .STUCK_LIMIT  (SLIM)
  ) dut (
    .clk_200KHz  (clk_200KHz),
    .rst_n       (rst_n),
    .en          (en),
    .temp_data   (temp_data),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .overrun     (overrun),
    .health_fail (health_fail)
  );

  always #5 clk_200KHz = ~clk_200KHz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // pre: 0 none, 1 drop en for one cycle first, 2 pulse rst_n first
  typedef struct {
    logic [1:0]  pre;
    logic [11:0] temp;
    logic        rp;
    logic        rt;
    logic        ev;
    logic [7:0]  ed;
    logic        eo;
    logic        eh;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] pre, input logic [11:0] t, input logic rp, input logic rt,
                     input logic ev, input logic [7:0] ed, input logic eo, input logic eh);
    vec_t v;
    v.pre = pre; v.temp = t; v.rp = rp; v.rt = rt;
    v.ev = ev; v.ed = ed; v.eo = eo; v.eh = eh;
    tbl.push_back(v);
  endtask

  // One byte as 8 unequal pairs (bit, ~bit) using 0x190/0x191
  task automatic add_byte(input logic [1:0] pre, input logic [7:0] b, input logic rt_last,
                          input logic ev_mid, input logic [7:0] ed_mid, input logic eo_mid,
                          input logic ev_last, input logic [7:0] ed_last, input logic eo_last);
    for (int i = 0; i < 8; i++) begin
      logic bt;
      bt = b[7-i];
      add((i == 0) ? pre : 2'd0, {11'h0C8, bt}, 1'b0, 1'b0, ev_mid, ed_mid, eo_mid, 1'b0);
      if (i == 7) add(2'd0, {11'h0C8, ~bt}, 1'b0, rt_last, ev_last, ed_last, eo_last, 1'b0);
      else        add(2'd0, {11'h0C8, ~bt}, 1'b0, 1'b0, ev_mid, ed_mid, eo_mid, 1'b0);
    end
  endtask

  // Drive one sample period; the 4th edge is the tick edge
  task automatic window(input logic [11:0] t, input logic rp, input logic rt, input logic exp_pre_v);
    temp_data = t;
    rnd_ready = rp;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_200KHz); #1;
      chk("valid_before_tick", rnd_valid, exp_pre_v);
    end
    rnd_ready = rt;
    @(posedge clk_200KHz); #1;
    rnd_ready = 1'b0;
  endtask

  task automatic en_drop(input logic ev, input logic [7:0] ed);
    rnd_ready = 1'b0;
    en = 1'b0;
    @(posedge clk_200KHz); #1;
    chk("en_drop_overrun", overrun, 1'b0);
    chk("en_drop_health", health_fail, 1'b0);
    chk("en_drop_valid_kept", rnd_valid, ev);
    chk("en_drop_data_kept", rnd_data, ed);
    en = 1'b1;
    @(posedge clk_200KHz); #1;
  endtask

  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", rnd_data, 8'h00);
    chk("async_rst_valid", rnd_valid, 1'b0);
    chk("async_rst_overrun", overrun, 1'b0);
    chk("async_rst_health", health_fail, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk_200KHz); #1;
  endtask

  // Behavioural reference: sample list -> unequal pairs -> bit queue -> bytes
  logic       mv, mo, mh;
  logic [7:0] md;
  logic       have_prev, have_first, first;
  logic [11:0] prev;
  int         run_len;
  bit         bitq[$];

  task automatic model_clear();
    mo = 1'b0; mh = 1'b0;
    have_prev = 1'b0; run_len = 0; have_first = 1'b0; first = 1'b0; prev = '0;
    bitq.delete();
  endtask

  task automatic model_tick(input logic [11:0] t, input logic rp, input logic rt);
    logic       done, raw;
    logic [7:0] byte_v;
    int         ones;
    done = 1'b0;
    byte_v = '0;
    if (mv && rp) mv = 1'b0;
    if (!mh) begin
      if (have_prev && t == prev) run_len++;
      else run_len = 1;
      prev = t;
      have_prev = 1'b1;
      if (run_len >= int'(SLIM)) begin
        mh = 1'b1;
        have_first = 1'b0;
        bitq.delete();
      end else begin
        ones = 0;
        for (int k = 0; k < int'(EBITS); k++) ones += int'(t[k]);
        raw = (ones % 2) == 1;
        if (!have_first) begin
          first = raw;
          have_first = 1'b1;
        end else begin
          have_first = 1'b0;
          if (first != raw) bitq.push_back(first);
        end
        if (bitq.size() == 8) begin
          for (int k = 0; k < 8; k++) byte_v = 8'((int'(byte_v) * 2) + int'(bitq[k]));
          bitq.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      if (!mv || rt) begin md = byte_v; mv = 1'b1; end
      else mo = 1'b1;
    end else if (mv && rt) begin
      mv = 1'b0;
    end
  endtask

  initial begin
    logic       pv;
    logic [7:0] pd;
    bit [19:0]  seq_a;
    logic       a;

    // Debias: pairs 01 10 00 11 01 10 01 10 01 10 -> emitted 01010101
    seq_a = 20'b0110_0011_0110_0110_0110;
    for (int i = 0; i < 20; i++) begin
      a = seq_a[19-i];
      add(2'd0, {11'h0C8, a}, 1'b0, 1'b0, (i == 19), (i == 19) ? 8'h55 : 8'h00, 1'b0, 1'b0);
    end
    // Overrun: second byte completes while 0x55 is still pending, then accept
    add_byte(2'd0, 8'hFF, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1);
    add(2'd0, 12'h190, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
    // Simultaneous accept and completion
    add_byte(2'd1, 8'hA5, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 8'hA5, 1'b0);
    add_byte(2'd0, 8'h3C, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0);
    add(2'd0, 12'h190, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    // Stuck sensor: 4 equal samples trip the health check, then nothing more
    for (int i = 0; i < 4; i++)
      add(2'd0, 12'h1A0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, (i == 3));
    add(2'd0, 12'h191, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    add(2'd0, 12'h190, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    // Restart after en drop, then 5 bits of a partial byte
    add_byte(2'd1, 8'h96, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h96, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add(2'd0, 12'h191, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0);
      add(2'd0, 12'h190, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0);
    end
    // Async reset mid-byte; next byte built from fresh bits only
    add_byte(2'd2, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b0);

    rst_n = 1'b0; en = 1'b0; rnd_ready = 1'b0; temp_data = '0;
    repeat (3) @(posedge clk_200KHz);
    #1;
    chk("reset_data", rnd_data, 8'h00);
    chk("reset_valid", rnd_valid, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_health", health_fail, 1'b0);
    rst_n = 1'b1;
    en = 1'b1;
    @(posedge clk_200KHz); #1;
    chk("enable_valid", rnd_valid, 1'b0);

    pv = 1'b0; pd = 8'h00;
    foreach (tbl[i]) begin
      if (tbl[i].pre == 2'd1) en_drop(pv, pd);
      if (tbl[i].pre == 2'd2) begin rst_pulse(); pv = 1'b0; pd = 8'h00; end
      window(tbl[i].temp, tbl[i].rp, tbl[i].rt, pv && !tbl[i].rp);
      chk("vec_valid", rnd_valid, tbl[i].ev);
      chk("vec_data", rnd_data, tbl[i].ed);
      chk("vec_overrun", overrun, tbl[i].eo);
      chk("vec_health", health_fail, tbl[i].eh);
      pv = tbl[i].ev;
      pd = tbl[i].ed;
    end

    // Randomized run against the reference model
    mv = pv; md = pd;
    model_clear();
    en_drop(mv, md);
    for (int n = 0; n < 300; n++) begin
      logic [11:0] t;
      logic        rp, rt;
      t  = 12'h100 + 12'($urandom_range(0, 3));
      rp = ($urandom_range(0, 3) == 0);
      rt = 1'($urandom_range(0, 1));
      window(t, rp, rt, mv && !rp);
      model_tick(t, rp, rt);
      chk("rand_valid", rnd_valid, mv);
      chk("rand_data", rnd_data, md);
      chk("rand_overrun", overrun, mo);
      chk("rand_health", health_fail, mh);
      if (mh || $urandom_range(0, 49) == 0) begin
        en_drop(mv, md);
        model_clear();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
